fetch_stage: RTL

- Instruction-fetch stage and IF/ID pipeline latch of the pipelined MIPS core.
- Owns the PC, issues instruction-memory reads and captures returned words.
- Presents the latched instruction to decode, which feeds opcode/funct straight to the control unit.
- Handles hazard stalls, EX-stage redirects (branch/jump squash) and HALT freezing.

---
 rtl/fetch_stage.sv | 117 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline latch.
// Owns the PC, accepts instruction words, and handles stall, redirect and HALT.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h00000000,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_out,
    output logic [31:0] npc_out,
    output logic [5:0]  opcode_out,
    output logic [5:0]  funct_out,
    output logic        valid_out,
    output logic        halted,
    output logic [31:0] fetch_cnt
);

    // state  | meaning
    // RUN    | fetching; a returned word is latched into IF/ID
    // HALTED | HALT latched in IF/ID; PC, IF/ID and count frozen until redirect
    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] npc_q, npc_d;
    logic        valid_q, valid_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
            pc_q    <= PC_INIT;
            instr_q <= '0;
            npc_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        npc_d   = npc_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        if (redirect) begin
            // Squash IF/ID; any word returned this cycle belongs to the wrong path.
            pc_d    = redirect_pc & 32'hFFFF_FFFC;
            instr_d = '0;
            npc_d   = '0;
            valid_d = 1'b0;
            state_d = RUN;
        end else if (stall) begin
            state_d = state_q;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (ihit) begin
                        instr_d = imemload;
                        npc_d   = pc_plus4;
                        valid_d = 1'b1;
                        cnt_d   = cnt_q + 32'd1;
                        if (imemload[31:26] == HALT_OP) begin
                            state_d = HALTED;
                        end else begin
                            pc_d = pc_plus4;
                        end
                    end else begin
                        instr_d = '0;
                        npc_d   = '0;
                        valid_d = 1'b0;
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    assign imemREN    = (state_q == RUN);
    assign imemaddr   = pc_q;
    assign halted     = (state_q == HALTED);
    assign instr_out  = instr_q;
    assign npc_out    = npc_q;
    assign opcode_out = instr_q[31:26];
    assign funct_out  = instr_q[5:0];
    assign valid_out  = valid_q;
    assign fetch_cnt  = cnt_q;

endmodule
